// File: rtl/alarm_pkg.sv
// Shared types and constants for the egg-timer alarm sequencer.
// The state encoding is fixed because status logic elsewhere decodes the raw value.
package alarm_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      BEEP  = 3'd1,
      GAP   = 3'd2,
      PAUSE = 3'd3,
      HOLD  = 3'd4
   } alarm_state_e;

   localparam int BURST_W = 5;

   // Cycle count for a duration in milliseconds. 64-bit math, because
   // 1000 ms at 5 MHz overflows 32 bits before the divide.
   function automatic int ms2cyc(input int ms, input int clk_hz);
      longint cyc;
      cyc = longint'(ms) * longint'(clk_hz) / longint'(1000);
      return int'(cyc);
   endfunction

   // Width of a counter that runs 0 .. n-1. Sizes the phase and tone counters.
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/alarm_sequencer_tone_gen.sv
// Speaker square-wave generator: toggles every HALF enabled cycles and is
// held at zero (counter cleared) while en is low.
module tone_gen
   import alarm_pkg::*;
#(
   parameter int HALF = 1250
) (
   input  logic clk_5MHz,
   input  logic reset,
   input  logic en,
   output logic speaker
);

   localparam int TONE_W = cnt_w(HALF);
   localparam logic [TONE_W-1:0] TONE_TC = TONE_W'(HALF - 1);

   logic [TONE_W-1:0] tone_cnt;

   always_ff @(posedge clk_5MHz or posedge reset) begin
      if (reset) begin
         tone_cnt <= '0;
         speaker  <= 1'b0;
      end else if (!en) begin
         tone_cnt <= '0;
         speaker  <= 1'b0;
      end else if (tone_cnt == TONE_TC) begin
         tone_cnt <= '0;
         speaker  <= ~speaker;
      end else begin
         tone_cnt <= tone_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm pattern sequencer: bursts of beeps driven from the timer's done level.
//
//   state | meaning
//   IDLE  | waiting for a rising edge of done (with enable high)
//   BEEP  | tone on for one beep
//   GAP   | silence between beeps of a burst
//   PAUSE | silence after the last beep of a burst
//   HOLD  | stopped (ack, enable low or timeout); waits for done to fall
module alarm_sequencer
   import alarm_pkg::*;
#(
   parameter int CLK_HZ         = 5_000_000,
   parameter int TONE_HZ        = 2000,
   parameter int BEEP_MS        = 200,
   parameter int GAP_MS         = 200,
   parameter int PAUSE_MS       = 1000,
   parameter int BEEPS          = 3,
   parameter int TIMEOUT_BURSTS = 20
) (
   input  logic               clk_5MHz,
   input  logic               reset,
   input  logic               enable,
   input  logic               done,
   input  logic               ack,
   output logic               speaker,
   output logic               alarm_active,
   output logic               led_flash,
   output logic [BURST_W-1:0] burst_count,
   output logic               timed_out
);

   localparam int HALF      = CLK_HZ / (2 * TONE_HZ);
   localparam int BEEP_CYC  = ms2cyc(BEEP_MS, CLK_HZ);
   localparam int GAP_CYC   = ms2cyc(GAP_MS, CLK_HZ);
   localparam int PAUSE_CYC = ms2cyc(PAUSE_MS, CLK_HZ);
   localparam int BG_MAX    = (BEEP_CYC > GAP_CYC) ? BEEP_CYC : GAP_CYC;
   localparam int MAX_CYC   = (BG_MAX > PAUSE_CYC) ? BG_MAX : PAUSE_CYC;
   localparam int PHASE_W   = cnt_w(MAX_CYC);
   localparam int IDX_W     = cnt_w(BEEPS);

   localparam logic [PHASE_W-1:0] BEEP_TC   = PHASE_W'(BEEP_CYC - 1);
   localparam logic [PHASE_W-1:0] GAP_TC    = PHASE_W'(GAP_CYC - 1);
   localparam logic [PHASE_W-1:0] PAUSE_TC  = PHASE_W'(PAUSE_CYC - 1);
   localparam logic [IDX_W-1:0]   LAST_BEEP = IDX_W'(BEEPS - 1);
   localparam logic [BURST_W-1:0] TIMEOUT_N = BURST_W'(TIMEOUT_BURSTS);

   alarm_state_e       state_q;
   alarm_state_e       state_nxt;
   logic               done_d;
   logic               ack_d;
   logic               armed;
   logic               trig;
   logic               ack_rise;
   logic               stop_req;
   logic               phase_end;
   logic               advance;
   logic               last_burst;
   logic               timeout_q;
   logic               tone_en;
   logic [PHASE_W-1:0] phase_cnt;
   logic [IDX_W-1:0]   beep_idx;
   logic [BURST_W-1:0] burst_q;

   // armed stays low after reset until done is seen low, so a done level
   // left high across a reset cannot look like a fresh rising edge.
   assign trig       = done & ~done_d & enable & armed;
   assign ack_rise   = ack & ~ack_d;
   assign stop_req   = ack_rise | ~enable;
   assign advance    = done & ~stop_req & phase_end;
   assign last_burst = ((burst_q + 5'd1) == TIMEOUT_N);

   always_comb begin
      phase_end = 1'b0;
      case (state_q)
         BEEP:    phase_end = (phase_cnt == BEEP_TC);
         GAP:     phase_end = (phase_cnt == GAP_TC);
         PAUSE:   phase_end = (phase_cnt == PAUSE_TC);
         default: phase_end = 1'b0;
      endcase
   end

   always_ff @(posedge clk_5MHz or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         IDLE: begin
            if (trig) state_nxt = BEEP;
         end
         BEEP, GAP, PAUSE: begin
            if (!done) begin
               state_nxt = IDLE;
            end else if (stop_req) begin
               state_nxt = HOLD;
            end else if (phase_end) begin
               if (state_q == BEEP) begin
                  state_nxt = (beep_idx < LAST_BEEP) ? GAP : PAUSE;
               end else if (state_q == GAP) begin
                  state_nxt = BEEP;
               end else begin
                  state_nxt = last_burst ? HOLD : BEEP;
               end
            end
         end
         HOLD: begin
            if (!done) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      alarm_active = (state_q == BEEP) || (state_q == GAP) || (state_q == PAUSE);
      led_flash    = (state_q == BEEP);
      timed_out    = (state_q == HOLD) && timeout_q;
      burst_count  = burst_q;
      // Tone runs only while staying in BEEP, so the registered speaker is
      // already 0 on the cycle after BEEP is left and starts clean on entry.
      tone_en      = (state_q == BEEP) && (state_nxt == BEEP);
   end

   always_ff @(posedge clk_5MHz or posedge reset) begin
      if (reset) begin
         done_d    <= 1'b0;
         ack_d     <= 1'b0;
         armed     <= 1'b0;
         phase_cnt <= '0;
         beep_idx  <= '0;
         burst_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         done_d <= done;
         ack_d  <= ack;
         if (!done) armed <= 1'b1;

         if ((state_nxt != state_q) || (state_q == IDLE) || (state_q == HOLD)) begin
            phase_cnt <= '0;
         end else begin
            phase_cnt <= phase_cnt + 1'b1;
         end

         if ((state_q == IDLE) && (state_nxt == BEEP)) begin
            beep_idx <= '0;
            burst_q  <= '0;
         end else if ((state_q == GAP) && advance) begin
            beep_idx <= beep_idx + 1'b1;
         end else if ((state_q == PAUSE) && advance) begin
            beep_idx <= '0;
            if (burst_q != TIMEOUT_N) burst_q <= burst_q + 1'b1;
         end

         timeout_q <= (state_nxt == HOLD) &&
                      ((state_q == HOLD) ? timeout_q
                                         : ((state_q == PAUSE) && advance && last_burst));
      end
   end

   tone_gen #(
      .HALF (HALF)
   ) u_tone_gen (
      .clk_5MHz (clk_5MHz),
      .reset    (reset),
      .en       (tone_en),
      .speaker  (speaker)
   );

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed bench for alarm_sequencer with short durations:
// HALF=5, beep/gap 20 cycles, pause 50 cycles, 3 beeps, timeout after 2 bursts.
module tb_alarm_sequencer;
   import alarm_pkg::*;

   logic       clk_5MHz = 1'b0;
   logic       reset;
   logic       enable;
   logic       done;
   logic       ack;
   logic       speaker;
   logic       alarm_active;
   logic       led_flash;
   logic [4:0] burst_count;
   logic       timed_out;

   int n_checks = 0;
   int n_errors = 0;

   int kb;
   int led_cyc;
   int bad_led;
   int bad_spk;
   int bad_act;
   int bad_burst;
   logic in_beep;
   logic exp_spk;

   always #50 clk_5MHz = ~clk_5MHz;

   alarm_sequencer #(
      .CLK_HZ         (10_000),
      .TONE_HZ        (1000),
      .BEEP_MS        (2),
      .GAP_MS         (2),
      .PAUSE_MS       (5),
      .BEEPS          (3),
      .TIMEOUT_BURSTS (2)
   ) dut (
      .clk_5MHz     (clk_5MHz),
      .reset        (reset),
      .enable       (enable),
      .done         (done),
      .ack          (ack),
      .speaker      (speaker),
      .alarm_active (alarm_active),
      .led_flash    (led_flash),
      .burst_count  (burst_count),
      .timed_out    (timed_out)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_5MHz);
         #1;
      end
   endtask

   initial begin
      reset  = 1'b1;
      enable = 1'b1;
      done   = 1'b0;
      ack    = 1'b0;
      #10;
      chk("rst_active",  32'(alarm_active), 32'd0);
      chk("rst_led",     32'(led_flash),    32'd0);
      chk("rst_speaker", 32'(speaker),      32'd0);
      chk("rst_burst",   32'(burst_count),  32'd0);
      chk("rst_timeout", 32'(timed_out),    32'd0);
      tick(2);
      reset = 1'b0;
      tick(2);

      // basic pattern followed by timeout after two bursts
      done = 1'b1;
      tick(1);
      chk("start_active", 32'(alarm_active), 32'd1);
      chk("start_led",    32'(led_flash),    32'd1);
      chk("start_spk",    32'(speaker),      32'd0);
      led_cyc = 1; bad_led = 0; bad_spk = 0; bad_act = 0; bad_burst = 0;
      for (int k = 1; k < 300; k++) begin
         tick(1);
         kb      = k % 150;
         in_beep = (kb < 100) && ((kb % 40) < 20);
         exp_spk = in_beep ? 1'(((kb % 40) / 5) % 2) : 1'b0;
         if (led_flash !== in_beep) bad_led++;
         if (speaker !== exp_spk) bad_spk++;
         if (alarm_active !== 1'b1) bad_act++;
         if (burst_count !== 5'(k / 150)) bad_burst++;
         if (led_flash === 1'b1) led_cyc++;
         if (k == 150) chk("burst1_count", 32'(burst_count), 32'd1);
         if (k == 149) chk("pause_end_burst", 32'(burst_count), 32'd0);
      end
      chk("pattern_led_errs",   32'(bad_led),   32'd0);
      chk("pattern_spk_errs",   32'(bad_spk),   32'd0);
      chk("pattern_act_errs",   32'(bad_act),   32'd0);
      chk("pattern_burst_errs", 32'(bad_burst), 32'd0);
      chk("pattern_led_cycles", 32'(led_cyc),   32'd120);
      tick(1);
      chk("to_timed_out", 32'(timed_out),    32'd1);
      chk("to_active",    32'(alarm_active), 32'd0);
      chk("to_burst",     32'(burst_count),  32'd2);
      chk("to_state",     32'(dut.state_q),  32'(HOLD));
      done = 1'b0;
      tick(1);
      chk("to_idle_state", 32'(dut.state_q), 32'(IDLE));
      chk("to_idle_flag",  32'(timed_out),   32'd0);

      // acknowledge during second beep
      done = 1'b1;
      tick(1);
      tick(46);
      chk("ack_pre_spk", 32'(speaker), 32'd1);
      ack = 1'b1;
      tick(1);
      chk("ack_state",   32'(dut.state_q),  32'(HOLD));
      chk("ack_spk",     32'(speaker),      32'd0);
      chk("ack_led",     32'(led_flash),    32'd0);
      chk("ack_active",  32'(alarm_active), 32'd0);
      chk("ack_timeout", 32'(timed_out),    32'd0);
      ack = 1'b0;
      tick(5);
      chk("hold_no_retrig", 32'(dut.state_q), 32'(HOLD));
      done = 1'b0;
      tick(1);
      chk("hold_to_idle", 32'(dut.state_q), 32'(IDLE));
      done = 1'b1;
      tick(1);
      chk("retrig_state", 32'(dut.state_q), 32'(BEEP));

      // ack coincident with BEEP expiry
      tick(19);
      ack = 1'b1;
      tick(1);
      chk("ack_vs_expiry", 32'(dut.state_q), 32'(HOLD));
      ack  = 1'b0;
      done = 1'b0;
      tick(1);

      // done falling together with ack
      done = 1'b1;
      tick(1);
      tick(3);
      done = 1'b0;
      ack  = 1'b1;
      tick(1);
      chk("done_vs_ack", 32'(dut.state_q), 32'(IDLE));
      ack = 1'b0;
      tick(1);
      ack = 1'b1;
      tick(1);
      chk("idle_ack_ignored", 32'(dut.state_q), 32'(IDLE));
      ack = 1'b0;
      tick(1);

      // ack coincident with trig starts the alarm
      done = 1'b1;
      ack  = 1'b1;
      tick(1);
      chk("ack_with_trig", 32'(dut.state_q), 32'(BEEP));
      ack  = 1'b0;
      done = 1'b0;
      tick(1);

      // enable gating
      enable = 1'b0;
      done   = 1'b1;
      tick(3);
      chk("disabled_state",  32'(dut.state_q),  32'(IDLE));
      chk("disabled_active", 32'(alarm_active), 32'd0);
      enable = 1'b1;
      tick(2);
      chk("enable_no_edge", 32'(dut.state_q), 32'(IDLE));
      done = 1'b0;
      tick(1);
      done = 1'b1;
      tick(1);
      tick(25);
      chk("gap_state",  32'(dut.state_q),  32'(GAP));
      chk("gap_led",    32'(led_flash),    32'd0);
      chk("gap_active", 32'(alarm_active), 32'd1);
      enable = 1'b0;
      tick(1);
      chk("dis_gap_state",   32'(dut.state_q),  32'(HOLD));
      chk("dis_gap_timeout", 32'(timed_out),    32'd0);
      chk("dis_gap_active",  32'(alarm_active), 32'd0);
      enable = 1'b1;
      done   = 1'b0;
      tick(1);

      // reset mid-beep
      done = 1'b1;
      tick(1);
      tick(7);
      chk("prerst_spk", 32'(speaker), 32'd1);
      reset = 1'b1;
      #1;
      chk("midrst_spk",    32'(speaker),      32'd0);
      chk("midrst_led",    32'(led_flash),    32'd0);
      chk("midrst_active", 32'(alarm_active), 32'd0);
      chk("midrst_state",  32'(dut.state_q),  32'(IDLE));
      tick(2);
      reset = 1'b0;
      tick(5);
      chk("postrst_state",  32'(dut.state_q),  32'(IDLE));
      chk("postrst_active", 32'(alarm_active), 32'd0);
      done = 1'b0;
      tick(1);
      done = 1'b1;
      tick(1);
      chk("postrst_retrig", 32'(alarm_active), 32'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
